// File: rtl/greyscale_fb_reader.sv
// Read side of the packed greyscale frame buffer: maps display raster to camera
// coordinates, fetches the 48-bit word holding six pixels and unpacks one byte.
module greyscale_fb_reader #(
  parameter int H_CAM       = 320,
  parameter int V_CAM       = 240,
  parameter int SCALE_SHIFT = 1,
  parameter int RAM_LATENCY = 2
) (
  input  logic        clk_pixel,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        ad_in,
  output logic [16:0] addr_out,
  input  logic [47:0] data_in,
  output logic [7:0]  pixel_out,
  output logic        in_frame_out,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        ad_out
);

  localparam int          LATENCY  = 4 + RAM_LATENCY;
  localparam logic [10:0] HCamW    = 11'(H_CAM);
  localparam logic [9:0]  VCamW    = 10'(V_CAM);
  // ceil(2^18/6); exact floor(n/6) for every n below 2^17/... well past 76799
  localparam logic [34:0] RecipSix = 35'd43691;

  logic [10:0] x_d, x_q;
  logic [9:0]  y_d, y_q;
  logic        inf1_d, inf1_q;
  logic [16:0] n_d, n_q;
  logic        inf2_q;
  logic [34:0] prod;
  logic [16:0] word_d, word_q;
  logic [2:0]  slot_d, slot_q;
  logic        inf3_q;
  logic [16:0] addr_q;
  logic [2:0]  slotPipe_q [RAM_LATENCY+1];
  logic [RAM_LATENCY:0] infPipe_q;
  logic [47:0] data_q;
  logic [7:0]  byteSel;
  logic [7:0]  pixel_q;
  logic        inFrame_q;
  logic [10:0] hPipe_q [LATENCY+1];
  logic [9:0]  vPipe_q [LATENCY+1];
  logic [LATENCY:0] adPipe_q;

  // 320*y is formed as (y<<8)+(y<<6) so no generic multiplier is inferred
  always_comb begin
    x_d    = hcount_in >> SCALE_SHIFT;
    y_d    = vcount_in >> SCALE_SHIFT;
    inf1_d = ad_in && (x_d < HCamW) && (y_d < VCamW);
    n_d    = {6'd0, x_q} + ({7'd0, y_q} << 8) + ({7'd0, y_q} << 6);
    prod   = 35'(n_q) * RecipSix;
    word_d = 17'(prod >> 18);
    slot_d = 3'(n_q - ((word_d << 2) + (word_d << 1)));
  end

  always_comb begin
    byteSel = 8'd0;
    case (slotPipe_q[RAM_LATENCY])
      3'd0:    byteSel = data_q[47:40];
      3'd1:    byteSel = data_q[39:32];
      3'd2:    byteSel = data_q[31:24];
      3'd3:    byteSel = data_q[23:16];
      3'd4:    byteSel = data_q[15:8];
      3'd5:    byteSel = data_q[7:0];
      default: byteSel = 8'd0;
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (rst_in) begin
      x_q       <= '0;
      y_q       <= '0;
      inf1_q    <= 1'b0;
      n_q       <= '0;
      inf2_q    <= 1'b0;
      word_q    <= '0;
      slot_q    <= '0;
      inf3_q    <= 1'b0;
      addr_q    <= '0;
      infPipe_q <= '0;
      data_q    <= '0;
      pixel_q   <= '0;
      inFrame_q <= 1'b0;
      adPipe_q  <= '0;
      for (int i = 0; i <= RAM_LATENCY; i++) slotPipe_q[i] <= '0;
      for (int i = 0; i <= LATENCY; i++) begin
        hPipe_q[i] <= '0;
        vPipe_q[i] <= '0;
      end
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      inf1_q <= inf1_d;
      n_q    <= n_d;
      inf2_q <= inf1_q;
      word_q <= word_d;
      slot_q <= slot_d;
      inf3_q <= inf2_q;
      // Hold the address outside the frame to avoid needless BRAM toggling
      if (inf3_q) addr_q <= word_q;
      slotPipe_q[0] <= slot_q;
      infPipe_q[0]  <= inf3_q;
      for (int i = 1; i <= RAM_LATENCY; i++) begin
        slotPipe_q[i] <= slotPipe_q[i-1];
        infPipe_q[i]  <= infPipe_q[i-1];
      end
      data_q    <= data_in;
      pixel_q   <= infPipe_q[RAM_LATENCY] ? byteSel : 8'd0;
      inFrame_q <= infPipe_q[RAM_LATENCY];
      hPipe_q[0]  <= hcount_in;
      vPipe_q[0]  <= vcount_in;
      adPipe_q[0] <= ad_in;
      for (int i = 1; i <= LATENCY; i++) begin
        hPipe_q[i]  <= hPipe_q[i-1];
        vPipe_q[i]  <= vPipe_q[i-1];
        adPipe_q[i] <= adPipe_q[i-1];
      end
    end
  end

  assign addr_out     = addr_q;
  assign pixel_out    = pixel_q;
  assign in_frame_out = inFrame_q;
  assign hcount_out   = hPipe_q[LATENCY];
  assign vcount_out   = vPipe_q[LATENCY];
  assign ad_out       = adPipe_q[LATENCY];

endmodule

// File: doc/greyscale_fb_reader.md
# greyscale_fb_reader

Read side of the packed greyscale frame buffer. The camera path writes 8-bit luma six pixels per 48-bit BRAM word, at word address (x + 320·y)/6, with the first pixel of each group in the top byte. This block takes the display raster counters from `video_sig_gen` and scales them down to camera coordinates. It then issues BRAM read addresses, unpacks the addressed byte, and delivers a pixel stream. Display-side counters and sync are delayed by a matching amount so the output is aligned for the HDMI/TMDS stage.

## Interface
Parameters:
- H_CAM, 320, camera frame width in pixels
- V_CAM, 240, camera frame height in pixels
- SCALE_SHIFT, 1, display-to-camera scale as a power of two (x = hcount >> SCALE_SHIFT)
- RAM_LATENCY, 2, BRAM read latency in cycles from addr_out to valid data_in

Derived (localparam): LATENCY = 4 + RAM_LATENCY.

Ports:
- clk_pixel  in  1  74.25 MHz pixel clock; single clock domain
- rst_in  in  1  synchronous, active-high reset
- hcount_in  in  11  display horizontal count
- vcount_in  in  10  display vertical count
- ad_in  in  1  active-draw from video_sig_gen
- addr_out  out  17  BRAM read address, zero-extended word index
- data_in  in  48  BRAM read data
- pixel_out  out  8  greyscale pixel; 0 when outside the frame
- in_frame_out  out  1  pixel_out is sourced from the frame buffer
- hcount_out  out  11  hcount_in delayed LATENCY cycles
- vcount_out  out  10  vcount_in delayed LATENCY cycles
- ad_out  out  1  ad_in delayed LATENCY cycles

## Operation
- Stage 1 (registered):
  - x = hcount_in >> SCALE_SHIFT, y = vcount_in >> SCALE_SHIFT.
  - inf = ad_in && x < H_CAM && y < V_CAM.
- Stage 2: linear index n = x + H_CAM·y, 17 bits. The multiply is built from shifts and adds (320y = (y<<8)+(y<<6)); no generic multiplier.
- Stage 3: word = n / 6 and slot = n mod 6, registered.
  - Constant-divisor logic or a reciprocal multiply is acceptable.
  - The result must be exact for every n in 0..H_CAM·V_CAM−1 (max 76799, giving word 12799).
  - addr_out <= word when inf; addr_out holds its previous value when !inf, so no spurious address toggling.
- RAM_LATENCY stages: slot and inf travel through a shift register alongside the BRAM.
- Final stage:
  - Byte select: slot 0 → data_in[47:40], 1 → [39:32], 2 → [31:24], 3 → [23:16], 4 → [15:8], 5 → [7:0].
  - pixel_out <= inf ? byte : 8'd0.
  - in_frame_out <= inf.
- Slot values 6 and 7 cannot occur. If forced, the output must be 0.
- Packed words span row boundaries: the index is linear, so a word may hold the end of row y and the start of row y+1. No per-row alignment is applied.

## Timing
- Fully pipelined: one pixel accepted and one pixel produced every cycle, with no stalls and no handshake.
- Inputs sampled at edge k:
  - addr_out updates at edge k+3.
  - data_in is sampled at edge k+3+RAM_LATENCY.
  - pixel_out, in_frame_out, hcount_out, vcount_out and ad_out update together at edge k+LATENCY (k+6 by default).
- Reset, while rst_in is high at an edge:
  - addr_out, pixel_out, in_frame_out, hcount_out, vcount_out and ad_out all go to 0.
  - All internal pipeline valid/inf bits clear.
- Reset mid-frame: no stale in-frame pixel may emerge after deassertion. Outputs stay 0 or out-of-frame until fresh inputs have traversed LATENCY stages.
- Frame wrap (vcount returns to 0): no special handling; the pipeline continues seamlessly.
- Display areas beyond H_CAM<<SCALE_SHIFT or V_CAM<<SCALE_SHIFT: black, in_frame_out = 0.

## Test plan
- Reset: hold rst_in 3 cycles during a live raster → every output is 0 during reset. in_frame_out stays 0 for the first 6 cycles after release.
- Origin: hcount=0..11, vcount=0, ad=1, SCALE_SHIFT=1.
  - addr_out: 0 for 12 consecutive cycles.
  - pixel_out sequence: [47:40] twice, then [39:32] twice, and so on, each exactly 6 cycles after its input.
- Row-spanning word: display (636,0), (638,0), (0,2) → n = 318, 319, 320 → addr 53 with slots 0, 1, 2 → bytes [47:40], [39:32], [31:24].
- Last pixel: display (639,479) → n = 76799 → addr 12799, slot 5 → pixel_out = data_in[7:0].
- Out of frame:
  - (640,0) and (0,480) → in_frame_out = 0, pixel_out = 0, addr_out holds its prior value.
  - ad_in = 0 inside the frame → pixel_out = 0.
- Delay alignment: random hcount/vcount/ad stream checked against a reference model → hcount_out/vcount_out/ad_out equal the inputs delayed exactly 6 cycles. Repeat with RAM_LATENCY = 1 → delay is 5 cycles.
